// File: rtl/orb_frame_sync_if.sv
// ---------------------------------------------------------------------------
// orb_frame_sync_if
// Purpose : serial-in / word-out bundle between the loop-back serial source
//           and the Orbita M16 frame synchronizer.
// Signals : iBitEn, iSerial                   - bit strobe and line bit (to sync)
//           oWord, oAddr, oWordValid          - deserialized word and its address
//           oFrameStart, oLocked, oSyncErr    - frame/lock status (from sync)
// Modports: master - drives the serial line, observes the words
//           slave  - the synchronizer itself
// ---------------------------------------------------------------------------
interface orb_frame_sync_if #(
    parameter int unsigned WORD_BITS = 12,
    parameter int unsigned ADDR_W    = 11
) ();
    logic                 iBitEn;
    logic                 iSerial;
    logic [WORD_BITS-1:0] oWord;
    logic [ADDR_W-1:0]    oAddr;
    logic                 oWordValid;
    logic                 oFrameStart;
    logic                 oLocked;
    logic                 oSyncErr;

    modport master (
        output iBitEn, iSerial,
        input  oWord, oAddr, oWordValid, oFrameStart, oLocked, oSyncErr
    );

    modport slave (
        input  iBitEn, iSerial,
        output oWord, oAddr, oWordValid, oFrameStart, oLocked, oSyncErr
    );
endinterface

// File: rtl/orb_frame_sync.sv
// ---------------------------------------------------------------------------
// orb_frame_sync
// Purpose : receive-side frame synchronizer and word deserializer for the
//           Orbita M16 serial stream. Hunts for the sync word, confirms it on
//           consecutive frames, then emits words tagged with their address.
// Ports   : clk   - system clock, rising edge
//           reset - synchronous, active-high
//           bus   - orb_frame_sync_if.slave (serial in, word/status out)
// ---------------------------------------------------------------------------
module orb_frame_sync #(
    parameter int unsigned          WORD_BITS   = 12,
    parameter int unsigned          FRAME_WORDS = 2048,
    parameter int unsigned          ADDR_W      = 11,
    parameter logic [WORD_BITS-1:0] SYNC_WORD   = WORD_BITS'(12'hE24),
    parameter int unsigned          CONFIRM_N   = 2,
    parameter int unsigned          MISS_N      = 3
) (
    input logic             clk,
    input logic             reset,
    orb_frame_sync_if.slave bus
);

    localparam int unsigned BCNT_W = $clog2(WORD_BITS);
    localparam int unsigned FILL_W = $clog2(WORD_BITS + 1);
    localparam int unsigned HITS_W = $clog2(CONFIRM_N + 1);
    localparam int unsigned MISS_W = $clog2(MISS_N + 1);

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WORD_BITS - 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(WORD_BITS);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(WORD_BITS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [HITS_W-1:0] CONFIRM_V = HITS_W'(CONFIRM_N);
    localparam logic [MISS_W-1:0] MISS_V    = MISS_W'(MISS_N);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_VERIFY,
        ST_LOCK
    } state_t;

    state_t               r_state,   w_state_nxt;
    // The oldest bit would be shifted out on the next strobe without ever
    // being compared, so only WORD_BITS-1 bits of history are kept.
    logic [WORD_BITS-2:0] r_sr,      w_sr_nxt;
    logic [BCNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [ADDR_W-1:0]    r_waddr,   w_waddr_nxt;
    logic [FILL_W-1:0]    r_fill,    w_fill_nxt;
    logic [HITS_W-1:0]    r_hits,    w_hits_nxt;
    logic [MISS_W-1:0]    r_misses,  w_misses_nxt;

    logic [WORD_BITS-1:0] r_word,        w_word_nxt;
    logic [ADDR_W-1:0]    r_addr,        w_addr_nxt;
    logic                 r_word_valid,  w_word_valid_nxt;
    logic                 r_frame_start, w_frame_start_nxt;
    logic                 r_locked,      w_locked_nxt;
    logic                 r_sync_err,    w_sync_err_nxt;

    logic [WORD_BITS-1:0] w_shift;
    logic                 w_match;
    logic                 w_armed;
    logic                 w_word_done;
    logic [ADDR_W-1:0]    w_addr_cur;
    logic [HITS_W-1:0]    w_hits_inc;
    logic [MISS_W-1:0]    w_miss_inc;

    // Word as it will look once the current bit is shifted in.
    assign w_shift     = {r_sr, bus.iSerial};
    assign w_match     = (w_shift == SYNC_WORD);
    // Enough real bits seen since entering HUNT that no reset zeros remain.
    assign w_armed     = (r_fill >= FILL_ARM);
    assign w_word_done = (r_bit_cnt == BCNT_LAST);
    // r_waddr holds the address of the last completed word (sync = 0).
    assign w_addr_cur  = (r_waddr == ADDR_LAST) ? '0 : r_waddr + 1'b1;
    assign w_hits_inc  = r_hits + 1'b1;
    assign w_miss_inc  = r_misses + 1'b1;

    // Next-state, datapath and output decode.
    always_comb begin
        w_state_nxt       = r_state;
        w_sr_nxt          = r_sr;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_waddr_nxt       = r_waddr;
        w_fill_nxt        = r_fill;
        w_hits_nxt        = r_hits;
        w_misses_nxt      = r_misses;
        w_word_nxt        = r_word;
        w_addr_nxt        = r_addr;
        w_word_valid_nxt  = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_sync_err_nxt    = 1'b0;

        if (bus.iBitEn) begin
            w_sr_nxt = w_shift[WORD_BITS-2:0];
            if (r_fill != FILL_MAX) begin
                w_fill_nxt = r_fill + 1'b1;
            end

            case (r_state)
                ST_HUNT: begin
                    if (w_armed && w_match) begin
                        w_waddr_nxt   = '0;
                        w_bit_cnt_nxt = '0;
                        w_hits_nxt    = HITS_W'(1);
                        w_misses_nxt  = '0;
                        w_state_nxt   = (CONFIRM_N == 1) ? ST_LOCK : ST_VERIFY;
                    end
                end

                ST_VERIFY: begin
                    w_bit_cnt_nxt = w_word_done ? '0 : r_bit_cnt + 1'b1;
                    if (w_word_done) begin
                        w_waddr_nxt = w_addr_cur;
                        if (w_addr_cur == '0) begin
                            if (w_match) begin
                                w_hits_nxt = w_hits_inc;
                                if (w_hits_inc == CONFIRM_V) begin
                                    w_state_nxt  = ST_LOCK;
                                    w_misses_nxt = '0;
                                end
                            end else begin
                                w_sync_err_nxt = 1'b1;
                                w_state_nxt    = ST_HUNT;
                                w_fill_nxt     = '0;
                                w_hits_nxt     = '0;
                            end
                        end
                    end
                end

                ST_LOCK: begin
                    w_bit_cnt_nxt = w_word_done ? '0 : r_bit_cnt + 1'b1;
                    if (w_word_done) begin
                        w_waddr_nxt       = w_addr_cur;
                        w_word_nxt        = w_shift;
                        w_addr_nxt        = w_addr_cur;
                        w_word_valid_nxt  = 1'b1;
                        w_frame_start_nxt = (w_addr_cur == '0);
                        if (w_addr_cur == '0) begin
                            if (w_match) begin
                                w_misses_nxt = '0;
                            end else begin
                                w_sync_err_nxt = 1'b1;
                                w_misses_nxt   = w_miss_inc;
                                // Losing word is still emitted; lock drops with the error.
                                if (w_miss_inc == MISS_V) begin
                                    w_state_nxt  = ST_HUNT;
                                    w_fill_nxt   = '0;
                                    w_hits_nxt   = '0;
                                    w_misses_nxt = '0;
                                end
                            end
                        end
                    end
                end

                default: begin
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end

        w_locked_nxt = (w_state_nxt == ST_LOCK);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_HUNT;
            r_sr          <= '0;
            r_bit_cnt     <= '0;
            r_waddr       <= '0;
            r_fill        <= '0;
            r_hits        <= '0;
            r_misses      <= '0;
            r_word        <= '0;
            r_addr        <= '0;
            r_word_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sr          <= w_sr_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_waddr       <= w_waddr_nxt;
            r_fill        <= w_fill_nxt;
            r_hits        <= w_hits_nxt;
            r_misses      <= w_misses_nxt;
            r_word        <= w_word_nxt;
            r_addr        <= w_addr_nxt;
            r_word_valid  <= w_word_valid_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_locked      <= w_locked_nxt;
            r_sync_err    <= w_sync_err_nxt;
        end
    end

    assign bus.oWord       = r_word;
    assign bus.oAddr       = r_addr;
    assign bus.oWordValid  = r_word_valid;
    assign bus.oFrameStart = r_frame_start;
    assign bus.oLocked     = r_locked;
    assign bus.oSyncErr    = r_sync_err;

endmodule

// File: tb/tb_orb_frame_sync.sv
// ---------------------------------------------------------------------------
// tb_orb_frame_sync
// Purpose : self-checking bench for orb_frame_sync (16-word frames).
//           Stimulus pushes expected output events into a queue from a
//           bit-stream reference model; a monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_orb_frame_sync;

    localparam int unsigned WB = 12;
    localparam int unsigned FW = 16;
    localparam int unsigned AW = 4;
    localparam logic [11:0] SYNC = 12'hE24;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    orb_frame_sync_if #(.WORD_BITS(WB), .ADDR_W(AW)) bus ();

    orb_frame_sync #(
        .WORD_BITS  (WB),
        .FRAME_WORDS(FW),
        .ADDR_W     (AW),
        .SYNC_WORD  (SYNC),
        .CONFIRM_N  (2),
        .MISS_N     (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic        valid;
        logic        fs;
        logic        err;
        logic        locked;
        logic [11:0] word;
        logic [3:0]  addr;
    } ev_t;

    ev_t  exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   gap   = 4;
    bit   thru  = 1'b0;
    int   last_valid = -1;
    int   n_err = 0;
    logic rst_d = 1'b1;

    // Reference model: stream position arithmetic rather than counters.
    int          m_mode;   // 0 hunting, 1 confirming, 2 locked
    int          m_hunt;   // bits seen since hunting began
    int          m_align;  // bits since the end of the aligned sync word
    int          m_hits;
    int          m_miss;
    logic [11:0] m_hist;
    logic [11:0] m_last_word;
    logic [3:0]  m_last_addr;

    function automatic void model_reset();
        m_mode = 0; m_hunt = 0; m_align = 0; m_hits = 0; m_miss = 0;
        m_hist = '0; m_last_word = '0; m_last_addr = '0;
    endfunction

    function automatic void emit(input logic valid, input logic err);
        ev_t e;
        e.valid  = valid;
        e.fs     = valid && (m_last_addr == 4'd0);
        e.err    = err;
        e.locked = (m_mode == 2);
        e.word   = m_last_word;
        e.addr   = m_last_addr;
        exp_q.push_back(e);
    endfunction

    function automatic void model_bit(input logic b);
        int   addr;
        logic err;
        m_hist = {m_hist[10:0], b};
        if (m_mode == 0) begin
            m_hunt++;
            if (m_hunt >= 12 && m_hist == SYNC) begin
                m_align = 0;
                m_hits  = 1;
                m_mode  = 1;
            end
        end else begin
            m_align++;
            if (m_align % 12 == 0) begin
                addr = (m_align / 12) % FW;
                if (m_mode == 1) begin
                    if (addr == 0) begin
                        if (m_hist == SYNC) begin
                            m_hits++;
                            if (m_hits == 2) begin
                                m_mode = 2;
                                m_miss = 0;
                                emit(1'b0, 1'b0);
                            end
                        end else begin
                            m_mode = 0;
                            m_hunt = 0;
                            emit(1'b0, 1'b1);
                        end
                    end
                end else begin
                    err = (addr == 0) && (m_hist != SYNC);
                    if (addr == 0) begin
                        if (!err) m_miss = 0;
                        else begin
                            m_miss++;
                            if (m_miss == 3) begin
                                m_mode = 0;
                                m_hunt = 0;
                            end
                        end
                    end
                    m_last_word = m_hist;
                    m_last_addr = 4'(addr);
                    emit(1'b1, err);
                end
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Called at posedge+1; leaves the bench at posedge+1.
    task automatic send_bit(input logic b);
        bus.iBitEn  = 1'b1;
        bus.iSerial = b;
        model_bit(b);
        @(posedge clk); #1;
        if (gap > 1) begin
            bus.iBitEn = 1'b0;
            repeat (gap - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic send_word(input logic [11:0] w);
        for (int i = 11; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_frame(input logic [11:0] s);
        send_word(s);
        for (int a = 1; a < 16; a++) send_word(12'(a));
    endtask

    task automatic do_reset();
        bus.iBitEn = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        @(negedge clk);
        check("rst_word",   int'(bus.oWord),       0);
        check("rst_addr",   int'(bus.oAddr),       0);
        check("rst_valid",  int'(bus.oWordValid),  0);
        check("rst_fstart", int'(bus.oFrameStart), 0);
        check("rst_locked", int'(bus.oLocked),     0);
        check("rst_syncerr",int'(bus.oSyncErr),    0);
        @(posedge clk); #1;
    endtask

    always @(posedge clk) begin
        rst_d <= reset;
        cyc   <= cyc + 1;
    end

    // Monitor: every visible output event must match the next expected one.
    initial begin : monitor
        ev_t  act;
        ev_t  e;
        logic prev_locked;
        prev_locked = 1'b0;
        forever begin
            @(negedge clk);
            act = {bus.oWordValid, bus.oFrameStart, bus.oSyncErr, bus.oLocked,
                   bus.oWord, bus.oAddr};
            if (reset || rst_d) begin
                prev_locked = bus.oLocked;
            end else if (act.valid || act.fs || act.err || (act.locked != prev_locked)) begin
                total++;
                if (act.err) n_err++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event v/fs/err/lk=%b%b%b%b word=%h addr=%0d (nothing expected)",
                             act.valid, act.fs, act.err, act.locked, act.word, act.addr);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        bad++;
                        $display("FAIL event actual v/fs/err/lk=%b%b%b%b word=%h addr=%0d required v/fs/err/lk=%b%b%b%b word=%h addr=%0d",
                                 act.valid, act.fs, act.err, act.locked, act.word, act.addr,
                                 e.valid, e.fs, e.err, e.locked, e.word, e.addr);
                    end
                end
                prev_locked = act.locked;
                if (thru && act.valid) begin
                    if (last_valid >= 0) begin
                        total++;
                        if (cyc - last_valid != 12) begin
                            bad++;
                            $display("FAIL word_spacing actual=%0d required=12", cyc - last_valid);
                        end
                    end
                    last_valid = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int          e0;
        logic [11:0] w;
        bus.iBitEn  = 1'b0;
        bus.iSerial = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);

        // Fill guard into clean acquisition.
        do_reset();
        e0 = n_err;
        repeat (11) send_bit(1'b0);
        send_word(SYNC);
        for (int a = 1; a < 16; a++) send_word(12'(a));
        repeat (4) send_frame(SYNC);
        check("clean_locked", int'(bus.oLocked), 1);
        check("clean_syncerr", n_err - e0, 0);

        // Two misses then a good sync keep lock.
        e0 = n_err;
        send_frame(12'h000);
        send_frame(12'h000);
        send_frame(SYNC);
        check("two_miss_locked", int'(bus.oLocked), 1);
        check("two_miss_syncerr", n_err - e0, 2);

        // Three consecutive misses drop lock.
        e0 = n_err;
        repeat (3) send_frame(12'h000);
        check("loss_locked", int'(bus.oLocked), 0);
        check("loss_syncerr", n_err - e0, 3);
        repeat (3) send_frame(SYNC);
        check("relock_locked", int'(bus.oLocked), 1);

        // Reset after 7 bits of a word, then reacquire.
        w = 12'h005;
        for (int i = 11; i >= 5; i--) send_bit(w[i]);
        do_reset();
        e0 = n_err;
        repeat (3) send_frame(SYNC);
        check("midreset_locked", int'(bus.oLocked), 1);
        check("midreset_syncerr", n_err - e0, 0);

        // False sync at address 5 preceded by random bits.
        do_reset();
        e0 = n_err;
        repeat (13) send_bit(1'($urandom));
        for (int a = 0; a < 5; a++) send_word(12'($urandom) & 12'h7FF);
        send_word(SYNC);
        for (int a = 6; a < 16; a++) send_word(12'(a));
        repeat (5) send_frame(SYNC);
        check("false_syncerr_seen", int'((n_err - e0) >= 1), 1);
        check("false_locked", int'(bus.oLocked), 1);

        // Continuous bit strobes.
        do_reset();
        gap = 1;
        last_valid = -1;
        thru = 1'b1;
        repeat (4) send_frame(SYNC);
        bus.iBitEn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        thru = 1'b0;
        gap  = 4;
        check("thru_locked", int'(bus.oLocked), 1);

        // Random data with occasional corrupted syncs.
        do_reset();
        for (int f = 0; f < 8; f++) begin
            send_word(($urandom_range(0, 3) == 0) ? 12'($urandom) : SYNC);
            for (int a = 1; a < 16; a++) send_word(12'($urandom));
        end

        bus.iBitEn = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("drain_pending", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
